// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception encodings, vector and reset values.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_ADEL    = 32'h4;
    localparam logic [31:0] EXC_ADES    = 32'h5;
    localparam logic [31:0] EXC_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_BREAK   = 32'h9;
    localparam logic [31:0] EXC_RI      = 32'ha;
    localparam logic [31:0] EXC_OV      = 32'hc;
    localparam logic [31:0] EXC_ERET    = 32'he;

    localparam logic [4:0] EXCCODE_INT = 5'h00;

    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // True for anything that commits CP0 exception state (ERET only clears EXL).
    function automatic logic is_exception(input logic [31:0] et);
        return (et != EXC_NONE) && (et != EXC_ERET);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock; timer_int latches on a match.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        toggle_d  = ~toggle_q;
        count_d   = toggle_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        if (count_we_i) begin
            count_d = wdata_i;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
        end
        // Match is taken on the value Count is about to hold, so the flag rises on the same edge.
        if (compare_we_i) begin
            timer_int_d = 1'b0;
        end else begin
            timer_int_d = timer_int_q | ((compare_q != 32'd0) && (count_d == compare_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            toggle_q    <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            toggle_q    <= toggle_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception sequencer: commits EPC/Cause/Status/BadVAddr and drives the flush/redirect.
module cp0_exc_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count, compare;
    logic        timer_int;
    logic        exc, eret, mtc0;

    // Any exception or ERET squashes the MEM instruction, so its MTC0 must not land.
    assign exc  = is_exception(excepttype_i);
    assign eret = (excepttype_i == EXC_ERET);
    assign mtc0 = we_i && (excepttype_i == EXC_NONE);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0 && (waddr_i == CP0_COUNT)),
        .compare_we_i (mtc0 && (waddr_i == CP0_COMPARE)),
        .wdata_i      (data_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        cause_d[15]    = int_i[5] | timer_int;
        cause_d[14:10] = int_i[4:0];

        if (mtc0) begin
            case (waddr_i)
                CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                CP0_CAUSE:  cause_d  = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
                CP0_EPC:    epc_d    = data_i;
                default:    ;
            endcase
        end

        if (exc) begin
            // A nested exception keeps the original return point.
            if (!status_q[1]) begin
                epc_d       = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_d[31] = in_delayslot_i;
            end
            status_d[1]  = 1'b1;
            cause_d[6:2] = (excepttype_i == EXC_INT) ? EXCCODE_INT : excepttype_i[4:0];
            if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
                badvaddr_d = bad_addr_i;
            end
        end

        if (eret) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_q;
            CP0_COUNT:    data_o = count;
            CP0_COMPARE:  data_o = compare;
            CP0_STATUS:   data_o = status_q;
            CP0_CAUSE:    data_o = cause_q;
            CP0_EPC:      data_o = epc_q;
            default:      data_o = 32'd0;
        endcase
    end

    assign flush_o     = (excepttype_i != EXC_NONE);
    assign newpc_o     = eret ? epc_q : (exc ? EXC_VECTOR : 32'd0);
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus random traffic against a behavioural CP0 model.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        timer_int_o;

    cp0_exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .raddr_i        (raddr_i),
        .data_i         (data_i),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .bad_addr_i     (bad_addr_i),
        .data_o         (data_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .flush_o        (flush_o),
        .newpc_o        (newpc_o),
        .timer_int_o    (timer_int_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    // reference model: architectural view of the CP0 registers
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_tint;
    int          m_edges;
    bit          m_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_update();
        logic [31:0] et, cnt_n, code;
        bit exc, eret, mtc, tint_n, exl_old;
        if (rst) begin
            m_status  = 32'h0040_0000;
            m_cause   = 0;
            m_epc     = 0;
            m_badv    = 0;
            m_count   = 0;
            m_compare = 0;
            m_tint    = 0;
            m_edges   = 0;
            m_valid   = 1;
            return;
        end
        et      = excepttype_i;
        exc     = (et != 0) && (et != 32'he);
        eret    = (et == 32'he);
        mtc     = we_i && (et == 0);
        exl_old = m_status[1];
        m_edges++;

        // Count advances on every even-numbered edge after reset.
        cnt_n = m_count + ((m_edges % 2 == 0) ? 32'd1 : 32'd0);
        if (mtc && waddr_i == 5'd9) cnt_n = data_i;
        if (mtc && waddr_i == 5'd11) tint_n = 0;
        else tint_n = m_tint || ((m_compare != 0) && (cnt_n == m_compare));

        m_cause[15]    = int_i[5] | m_tint;
        m_cause[14:10] = int_i[4:0];

        if (mtc && waddr_i == 5'd12) m_status = (m_status & ~32'h0000FF03) | (data_i & 32'h0000FF03);
        if (mtc && waddr_i == 5'd13) m_cause[9:8] = data_i[9:8];
        if (mtc && waddr_i == 5'd14) m_epc = data_i;
        if (mtc && waddr_i == 5'd11) m_compare = data_i;

        if (exc) begin
            if (!exl_old) begin
                m_epc       = in_delayslot_i ? pc_i - 4 : pc_i;
                m_cause[31] = in_delayslot_i;
            end
            m_status[1]  = 1'b1;
            code         = (et == 32'h1) ? 32'h0 : (et & 32'h1f);
            m_cause[6:2] = code[4:0];
            if (et == 32'h4 || et == 32'h5) m_badv = bad_addr_i;
        end
        if (eret) m_status[1] = 1'b0;

        m_count = cnt_n;
        m_tint  = tint_n;
    endtask

    // Compare every observable output against the model, away from the clock edge.
    task automatic check_outputs();
        logic [31:0] et;
        et = excepttype_i;
        check("flush_o", {31'd0, flush_o}, {31'd0, (et != 0)});
        if (et == 32'he && m_valid) check("newpc_eret", newpc_o, m_epc);
        else if (et != 0) check("newpc_vec", newpc_o, 32'hBFC0_0380);
        if (m_valid) begin
            check("status_o", status_o, m_status);
            check("cause_o", cause_o, m_cause);
            check("epc_o", epc_o, m_epc);
            check("timer_int_o", {31'd0, timer_int_o}, {31'd0, m_tint});
            exp_q.push_back(m_read(raddr_i));
            check("data_o", data_o, exp_q.pop_front());
        end
    endtask

    // One clock: check at the falling edge, update the model at the rising edge, step past it.
    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        we_i           = 0;
        waddr_i        = 0;
        data_i         = 0;
        int_i          = 0;
        excepttype_i   = 0;
        pc_i           = 0;
        in_delayslot_i = 0;
        bad_addr_i     = 0;
    endtask

    task automatic drive_exc(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                             input logic [31:0] badaddr);
        excepttype_i   = et;
        pc_i           = pc;
        in_delayslot_i = ds;
        bad_addr_i     = badaddr;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1;
        waddr_i = a;
        data_i  = d;
        run_cycle();
        we_i    = 0;
    endtask

    task automatic random_inputs();
        logic [31:0] ets [13];
        ets = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h4, 32'h5,
                32'h8, 32'h9, 32'ha, 32'hc, 32'he};
        rst            = ($urandom_range(0, 60) == 0);
        excepttype_i   = ets[$urandom_range(0, 12)];
        we_i           = $urandom_range(0, 1);
        case ($urandom_range(0, 7))
            0: waddr_i = 5'd8;
            1: waddr_i = 5'd9;
            2: waddr_i = 5'd11;
            3: waddr_i = 5'd12;
            4: waddr_i = 5'd13;
            5: waddr_i = 5'd14;
            default: waddr_i = 5'($urandom_range(0, 31));
        endcase
        raddr_i = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0: data_i = 32'hFFFF_FFFF;
            1: data_i = 32'($urandom_range(0, 40));
            default: data_i = $urandom;
        endcase
        int_i          = 6'($urandom_range(0, 63));
        pc_i           = $urandom & 32'hFFFF_FFFC;
        in_delayslot_i = $urandom_range(0, 1);
        bad_addr_i     = $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        bit seen;
        idle_inputs();
        raddr_i = 5'd8;
        rst     = 1;
        run_cycle();
        run_cycle();
        rst = 0;

        // reset state
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_badvaddr", data_o, 32'd0);
        raddr_i = 5'd9;
        #1;
        check("rst_count", data_o, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);

        // overflow, not in a delay slot
        drive_exc(32'hc, 32'h8000_0100, 0, 32'h0);
        #1;
        check("ov_flush", {31'd0, flush_o}, 32'd1);
        check("ov_newpc", newpc_o, 32'hBFC0_0380);
        run_cycle();
        idle_inputs();
        #1;
        check("ov_epc", epc_o, 32'h8000_0100);
        check("ov_exccode", {27'd0, cause_o[6:2]}, 32'h0c);
        check("ov_exl", {31'd0, status_o[1]}, 32'd1);

        // ERET back out
        drive_exc(32'he, 32'h0, 0, 32'h0);
        #1;
        check("eret_newpc", newpc_o, 32'h8000_0100);
        check("eret_flush", {31'd0, flush_o}, 32'd1);
        run_cycle();
        idle_inputs();
        #1;
        check("eret_exl", {31'd0, status_o[1]}, 32'd0);

        // AdEL in a delay slot
        drive_exc(32'h4, 32'h8000_0204, 1, 32'h1234_5671);
        run_cycle();
        idle_inputs();
        raddr_i = 5'd8;
        #1;
        check("adel_epc", epc_o, 32'h8000_0200);
        check("adel_bd", {31'd0, cause_o[31]}, 32'd1);
        check("adel_badvaddr", data_o, 32'h1234_5671);
        check("adel_exccode", {27'd0, cause_o[6:2]}, 32'h04);

        // nested syscall with EXL=1, colliding with an MTC0 to EPC
        drive_exc(32'h8, 32'h9000_0000, 0, 32'h0);
        we_i    = 1;
        waddr_i = 5'd14;
        data_i  = 32'hDEAD_BEEF;
        run_cycle();
        idle_inputs();
        #1;
        check("nested_epc", epc_o, 32'h8000_0200);
        check("nested_exccode", {27'd0, cause_o[6:2]}, 32'h08);
        drive_exc(32'he, 32'h0, 0, 32'h0);
        run_cycle();
        idle_inputs();

        // timer: Compare=10, Count=0, wait for the match
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        raddr_i = 5'd9;
        seen    = 0;
        waited  = 0;
        while (!seen && waited < 40) begin
            run_cycle();
            waited++;
            if (timer_int_o) seen = 1;
        end
        check("timer_rise", {31'd0, timer_int_o}, 32'd1);
        check("timer_count_at_rise", data_o, 32'd10);
        check("timer_rise_latency", 32'(waited >= 19 && waited <= 20), 32'd1);
        run_cycle();
        check("timer_cause_ip7", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd0);
        #1;
        check("timer_clear", {31'd0, timer_int_o}, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            random_inputs();
            run_cycle();
        end
        idle_inputs();
        rst = 0;
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
